// File: rtl/conv_mac_unit_if.sv
// ---------------------------------------------------------------
// conv_mac_unit_if : row input / result output bundle for conv_mac_unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface conv_mac_unit_if #(
   parameter int OUT_W = 16
);
   logic              macrst_i;
   logic              data_valid_i;
   logic [23:0]       pixel_i;
   logic [23:0]       weight_i;
   logic [OUT_W-1:0]  result_o;
   logic              result_valid_o;
   logic              out_we_o;
   logic [7:0]        out_addr_o;
   logic              done_o;

   modport master (
      output macrst_i, data_valid_i, pixel_i, weight_i,
      input  result_o, result_valid_o, out_we_o, out_addr_o, done_o
   );

   modport slave (
      input  macrst_i, data_valid_i, pixel_i, weight_i,
      output result_o, result_valid_o, out_we_o, out_addr_o, done_o
   );
endinterface

`default_nettype wire

// File: rtl/conv_mac_unit.sv
// ---------------------------------------------------------------
// conv_mac_unit : 3x3 convolution MAC, one kernel row per valid cycle,
//                 ReLU/saturation and output-buffer addressing
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module conv_mac_unit #(
   parameter int OUT_W   = 16,
   parameter int RELU    = 1,
   parameter int NUM_OUT = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   conv_mac_unit_if.slave        bus
);
   localparam int         ACC_W       = 21;
   localparam logic [7:0] C_LAST_ADDR = 8'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               row_cnt_q, row_cnt_d;
   logic                     s1_valid_q, s1_last_q;
   logic signed [16:0]       p_q [3];
   logic signed [16:0]       w_prod [3];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  w_rowsum, w_final;
   logic [OUT_W-1:0]         result_q, result_d, w_sat;
   logic [7:0]               out_addr_q, out_addr_d;
   logic                     w_accept, w_s2_fire;

   assign w_accept  = bus.data_valid_i & ~bus.macrst_i;
   assign w_s2_fire = s1_valid_q & ~bus.macrst_i;

   // Pixels are unsigned, so each gets a zero sign bit before the signed multiply
   for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign w_prod[gi] = 17'(signed'({1'b0, bus.pixel_i[23-8*gi -: 8]}))
                        * 17'(signed'(bus.weight_i[23-8*gi -: 8]));
   end

   assign w_rowsum = ACC_W'(p_q[0]) + ACC_W'(p_q[1]) + ACC_W'(p_q[2]);
   assign w_final  = acc_q + w_rowsum;

   if (RELU != 0) begin : g_relu
      localparam int C_UMAX = (1 << OUT_W) - 1;
      always_comb begin
         w_sat = w_final[OUT_W-1:0];
         if (w_final < 0)
            w_sat = '0;
         else if (int'(w_final) > C_UMAX)
            w_sat = '1;
      end
   end else begin : g_signed
      localparam int C_SMAX = (1 << (OUT_W - 1)) - 1;
      localparam int C_SMIN = -(1 << (OUT_W - 1));
      always_comb begin
         w_sat = w_final[OUT_W-1:0];
         if (int'(w_final) > C_SMAX)
            w_sat = {1'b0, {(OUT_W-1){1'b1}}};
         else if (int'(w_final) < C_SMIN)
            w_sat = {1'b1, {(OUT_W-1){1'b0}}};
      end
   end

   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      acc_d      = acc_q;
      result_d   = result_q;
      out_addr_d = out_addr_q;

      // The address steps once the emit cycle is over, so it names the current result
      if (state_q == S_EMIT)
         out_addr_d = (out_addr_q == C_LAST_ADDR) ? 8'd0 : out_addr_q + 8'd1;

      if (bus.macrst_i) begin
         state_d   = S_IDLE;
         row_cnt_d = '0;
         acc_d     = '0;
      end else begin
         case (state_q)
            S_IDLE:  if (bus.data_valid_i) state_d = S_ACC;
            S_EMIT:  state_d = S_ACC;
            default: ;
         endcase

         if (w_accept)
            row_cnt_d = (row_cnt_q == 2'd2) ? 2'd0 : row_cnt_q + 2'd1;

         if (w_s2_fire) begin
            if (s1_last_q) begin
               acc_d    = '0;
               result_d = w_sat;
               state_d  = S_EMIT;
            end else begin
               acc_d    = w_final;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         row_cnt_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         acc_q      <= '0;
         result_q   <= '0;
         out_addr_q <= '0;
         for (int i = 0; i < 3; i++) p_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         s1_valid_q <= w_accept;
         acc_q      <= acc_d;
         result_q   <= result_d;
         out_addr_q <= out_addr_d;
         if (w_accept) begin
            s1_last_q <= (row_cnt_q == 2'd2);
            for (int i = 0; i < 3; i++) p_q[i] <= w_prod[i];
         end
      end
   end

   assign bus.result_o       = result_q;
   assign bus.result_valid_o = (state_q == S_EMIT);
   assign bus.out_we_o       = (state_q == S_EMIT);
   assign bus.out_addr_o     = out_addr_q;
   assign bus.done_o         = (state_q == S_EMIT) && (out_addr_q == C_LAST_ADDR);

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_unit.sv
// ---------------------------------------------------------------
// tb_conv_mac_unit : two instances (ReLU/128 and signed/4) driven in lockstep
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_conv_mac_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        drv_valid, drv_macrst;
   logic [23:0] drv_pixel, drv_weight;

   conv_mac_unit_if #(.OUT_W(16)) ifa ();
   conv_mac_unit_if #(.OUT_W(16)) ifb ();

   assign ifa.macrst_i = drv_macrst;   assign ifb.macrst_i = drv_macrst;
   assign ifa.data_valid_i = drv_valid; assign ifb.data_valid_i = drv_valid;
   assign ifa.pixel_i = drv_pixel;     assign ifb.pixel_i = drv_pixel;
   assign ifa.weight_i = drv_weight;   assign ifb.weight_i = drv_weight;

   conv_mac_unit #(.OUT_W(16), .RELU(1), .NUM_OUT(128)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   conv_mac_unit #(.OUT_W(16), .RELU(0), .NUM_OUT(4))   dut_b (.clk(clk), .rst(rst), .bus(ifb));

   always #5 clk = ~clk;

   typedef struct { int due; logic [15:0] res; } exp_t;
   typedef struct { logic [23:0] pix; logic [23:0] wgt; logic [15:0] exp_a; logic [15:0] exp_b; } vec_t;

   exp_t        expq [2][$];
   logic [23:0] win_p[$], win_w[$];
   int          addr_m [2];
   int          num_out [2] = '{128, 4};
   int          relu_m [2]  = '{1, 0};
   int          res_cnt [2] = '{0, 0};
   int          done_cnt [2] = '{0, 0};
   logic [15:0] last_res [2];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   vec_t        tbl [6];

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [15:0] sat_model(input int s, input int relu);
      if (relu != 0) begin
         if (s < 0) return 16'd0;
         if (s > 65535) return 16'hFFFF;
         return 16'(s);
      end
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   // Reference model: collect accepted rows, convolve whole windows arithmetically
   always @(posedge clk) if (rst) begin
      cyc++;
      if (drv_macrst) begin
         win_p.delete(); win_w.delete();
         for (int d = 0; d < 2; d++)
            while (expq[d].size() > 0 && expq[d][expq[d].size()-1].due >= cyc)
               void'(expq[d].pop_back());
      end else if (drv_valid) begin
         win_p.push_back(drv_pixel); win_w.push_back(drv_weight);
         if (win_p.size() == 3) begin
            int s;
            s = 0;
            for (int r = 0; r < 3; r++)
               for (int l = 0; l < 3; l++) begin
                  int pv, wv;
                  logic [7:0] wb;
                  pv = int'(win_p[r][23-8*l -: 8]);
                  wb = win_w[r][23-8*l -: 8];
                  wv = int'($signed(wb));
                  s += pv * wv;
               end
            for (int d = 0; d < 2; d++)
               expq[d].push_back('{due: cyc + 1, res: sat_model(s, relu_m[d])});
            win_p.delete(); win_w.delete();
         end
      end
   end

   task automatic monitor_one(input int i, input logic valid, input logic we,
                              input logic [15:0] res, input logic [7:0] addr, input logic done);
      check($sformatf("we_eq_valid%0d", i), int'(we), int'(valid));
      if (valid) begin
         res_cnt[i]++;
         last_res[i] = res;
         if (expq[i].size() == 0 || expq[i][0].due != cyc) begin
            check($sformatf("unexpected_result%0d", i), 1, 0);
         end else begin
            check($sformatf("result%0d", i), int'(res), int'(expq[i][0].res));
            void'(expq[i].pop_front());
         end
         check($sformatf("out_addr%0d", i), int'(addr), addr_m[i]);
         check($sformatf("done%0d", i), int'(done), int'(addr_m[i] == num_out[i] - 1));
         if (done) done_cnt[i]++;
         addr_m[i] = (addr_m[i] + 1) % num_out[i];
      end else begin
         check($sformatf("done_idle%0d", i), int'(done), 0);
         check($sformatf("addr_hold%0d", i), int'(addr), addr_m[i]);
         if (expq[i].size() > 0 && expq[i][0].due <= cyc) begin
            check($sformatf("missing_result%0d", i), 0, 1);
            void'(expq[i].pop_front());
         end
      end
   endtask

   always @(negedge clk) if (rst) begin
      monitor_one(0, ifa.result_valid_o, ifa.out_we_o, ifa.result_o, ifa.out_addr_o, ifa.done_o);
      monitor_one(1, ifb.result_valid_o, ifb.out_we_o, ifb.result_o, ifb.out_addr_o, ifb.done_o);
   end

   task automatic drive(input logic v, input logic m, input logic [23:0] p, input logic [23:0] w);
      drv_valid = v; drv_macrst = m; drv_pixel = p; drv_weight = w;
      @(posedge clk); #1;
      drv_valid = 1'b0; drv_macrst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 24'h0, 24'h0);
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      #1;
      check("rst_result_a", int'(ifa.result_o), 0);      check("rst_result_b", int'(ifb.result_o), 0);
      check("rst_valid_a", int'(ifa.result_valid_o), 0); check("rst_valid_b", int'(ifb.result_valid_o), 0);
      check("rst_we_a", int'(ifa.out_we_o), 0);           check("rst_we_b", int'(ifb.out_we_o), 0);
      check("rst_addr_a", int'(ifa.out_addr_o), 0);       check("rst_addr_b", int'(ifb.out_addr_o), 0);
      check("rst_done_a", int'(ifa.done_o), 0);           check("rst_done_b", int'(ifb.done_o), 0);
      expq[0].delete(); expq[1].delete(); win_p.delete(); win_w.delete();
      addr_m[0] = 0; addr_m[1] = 0;
      @(negedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int r0, d0, d1;
      drv_valid = 1'b0; drv_macrst = 1'b0; drv_pixel = '0; drv_weight = '0;
      rst = 1'b1;
      #1 reset_dut();

      tbl[0] = '{24'h010203, 24'h010101, 16'd18,    16'd18};
      tbl[1] = '{24'h0A0A0A, 24'hFFFFFF, 16'd0,     16'hFFA6};
      tbl[2] = '{24'hFFFFFF, 24'h7F7F7F, 16'hFFFF,  16'h7FFF};
      tbl[3] = '{24'hFF00FF, 24'h808080, 16'd0,     16'h8000};
      tbl[4] = '{24'h000000, 24'h7F807F, 16'd0,     16'd0};
      tbl[5] = '{24'h102030, 24'h01FF02, 16'd240,   16'd240};

      // Whole windows, latency and saturation corners
      for (int t = 0; t < 6; t++) begin
         for (int r = 0; r < 3; r++) drive(1'b1, 1'b0, tbl[t].pix, tbl[t].wgt);
         @(negedge clk);
         check($sformatf("tbl%0d_early", t), int'(ifa.result_valid_o), 0);
         @(negedge clk);
         check($sformatf("tbl%0d_valid", t), int'(ifa.result_valid_o), 1);
         check($sformatf("tbl%0d_res_a", t), int'(ifa.result_o), int'(tbl[t].exp_a));
         check($sformatf("tbl%0d_res_b", t), int'(ifb.result_o), int'(tbl[t].exp_b));
         #2 idle(1);
      end

      // Reset in the middle of a window: nothing stale afterwards
      drive(1'b1, 1'b0, 24'h010203, 24'h010101);
      drive(1'b1, 1'b0, 24'h010203, 24'h010101);
      r0 = res_cnt[0];
      #2 reset_dut();
      idle(5);
      check("no_stale_after_reset", res_cnt[0] - r0, 0);

      // Window interrupted by macrst, then a clean window
      r0 = res_cnt[0];
      drive(1'b1, 1'b0, 24'h010203, 24'h010101);
      drive(1'b1, 1'b0, 24'h010203, 24'h010101);
      drive(1'b1, 1'b1, 24'hFFFFFF, 24'h7F7F7F);
      for (int r = 0; r < 3; r++) drive(1'b1, 1'b0, 24'h010203, 24'h010101);
      idle(4);
      check("macrst_one_result", res_cnt[0] - r0, 1);
      check("macrst_result_val", int'(last_res[0]), 18);

      // macrst while the last row sits in stage 1: the window is dropped
      r0 = res_cnt[0];
      for (int r = 0; r < 3; r++) drive(1'b1, 1'b0, 24'h010203, 24'h010101);
      drive(1'b0, 1'b1, 24'h0, 24'h0);
      idle(4);
      check("macrst_late_drop", res_cnt[0] - r0, 0);

      // Gaps inside a window hold state
      r0 = res_cnt[0];
      drive(1'b1, 1'b0, 24'h010203, 24'h010101); idle(2);
      drive(1'b1, 1'b0, 24'h010203, 24'h010101); idle(3);
      drive(1'b1, 1'b0, 24'h010203, 24'h010101); idle(3);
      check("gap_one_result", res_cnt[0] - r0, 1);
      check("gap_result_val", int'(last_res[0]), 18);

      // Frame wrap on the NUM_OUT=4 instance
      reset_dut();
      d1 = done_cnt[1]; d0 = res_cnt[1];
      for (int r = 0; r < 12; r++) drive(1'b1, 1'b0, 24'h010203, 24'h010101);
      idle(4);
      check("frame_results", res_cnt[1] - d0, 4);
      check("frame_done", done_cnt[1] - d1, 1);
      check("frame_addr_wrap", int'(ifb.out_addr_o), 0);
      check("frame_addr_a", int'(ifa.out_addr_o), 4);

      // Randomized traffic against the model
      for (int k = 0; k < 800; k++) begin
         logic v, m;
         logic [23:0] p, w;
         int sel;
         v = ($urandom_range(0, 9) < 7);
         m = ($urandom_range(0, 24) == 0);
         sel = $urandom_range(0, 3);
         p = (sel == 0) ? 24'hFFFFFF : 24'($urandom);
         w = (sel == 0) ? 24'h7F7F7F : (sel == 1) ? 24'h808080 : 24'($urandom);
         drive(v, m, p, w);
      end
      idle(5);
      check("drain_a", expq[0].size(), 0);
      check("drain_b", expq[1].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
